sprite_frame_renderer: RTL and testbench
========================================

Name: sprite_frame_renderer

Overview:
Parametrised successor to the game datapath's draw loop. Redraws NUM_OBJ rectangular sprites once per frame, one pixel per accepted cycle, onto the VGA adapter's plot interface. On each frame_tick it latches the object positions supplied by the game control FSM. It erases every enabled object's previous footprint with the background colour, then draws every enabled object at its new position. It adds per-object enables, screen clipping, plot backpressure and frame-overrun detection.

Parameters:
NUM_OBJ, 2, number of objects (player, obstacles); index 0 drawn first.
SPR_W, 8, sprite width in pixels (power of two, >=2).
SPR_H, 8, sprite height in pixels (power of two, >=2).
X_W, 8, x coordinate width.
Y_W, 7, y coordinate width.
SCREEN_W, 160, visible width; pixels with x >= SCREEN_W are clipped.
SCREEN_H, 120, visible height; pixels with y >= SCREEN_H are clipped.

Ports:
clock  in  1  system clock, rising edge.
resetn  in  1  asynchronous, active-low reset.
frame_tick  in  1  start-of-frame request; sampled only in IDLE.
obj_x  in  NUM_OBJ*X_W  packed top-left x; object i at [i*X_W +: X_W].
obj_y  in  NUM_OBJ*Y_W  packed top-left y, same packing.
obj_colour  in  NUM_OBJ*3  packed 3-bit draw colour per object.
obj_en  in  NUM_OBJ  object i drawn this frame when 1.
bg_colour  in  3  erase colour.
plot_ready  in  1  adapter accepts the current pixel on a rising edge when plot=1.
x  out  X_W  pixel x.
y  out  Y_W  pixel y.
colour  out  3  pixel colour.
plot  out  1  pixel valid.
busy  out  1  high from latch until frame complete.
frame_done  out  1  one-cycle pulse at end of frame.
overrun  out  1  one-cycle pulse when frame_tick is high while busy.

Behaviour:
- Reset (async, resetn=0): x=0, y=0, colour=0, plot=0, busy=0, frame_done=0, overrun=0; FSM to IDLE; all old_valid bits cleared; shadow and old position registers cleared.
- All outputs are registered.
- States: IDLE, ERASE, DRAW, DONE.
- IDLE -> ERASE: on the edge sampling frame_tick=1. That edge latches obj_x/obj_y/obj_colour/obj_en into shadow registers, sets busy=1, and sets object index=0 and pixel counter=0. Inputs are ignored for the rest of the frame.
- Segment: one object in one phase. ERASE visits objects 0..NUM_OBJ-1, then DRAW visits objects 0..NUM_OBJ-1.
- ERASE segment i is active if old_valid[i]=1; it uses old_x[i]/old_y[i] and bg_colour.
- DRAW segment i is active if shadow en[i]=1; it uses shadow position and colour.
- Inactive segment: costs exactly one cycle with plot=0.
- Pixel counter: width log2(SPR_W*SPR_H). Row-major scan: col = cnt mod SPR_W, row = cnt / SPR_W.
- Pixel address: x = base_x + col, y = base_y + row, each computed one bit wider than the coordinate.
- Clipped pixel (wide sum >= SCREEN_W or >= SCREEN_H): plot=0 for one cycle; the counter advances unconditionally.
- Visible pixel: plot=1 with x/y/colour. All three are held stable until an edge with plot_ready=1. Then advance. No pixel is skipped or duplicated.
- Counter wraps to 0 at SPR_W*SPR_H-1, and the segment ends.
- DRAW -> DONE after the last DRAW segment completes.
- DONE (one cycle): frame_done=1, busy=0, plot=0. old_x/old_y are copied from the shadow registers, and old_valid is copied from shadow en. Next state is IDLE.
- A disabled object is erased this frame (if previously valid), is not drawn, and is not erased next frame.
- Latency, all segments active, plot_ready=1, no clipping: first plot=1 on the cycle after the latch edge. Frame length is 2*NUM_OBJ*SPR_W*SPR_H pixel cycles plus the DONE cycle.
- frame_tick while busy (including the DONE cycle): ignored, overrun pulses for that cycle, and no state change.
- Reset mid-frame: frame is abandoned. The next frame performs no erase, so stale pixels remain; this is accepted.

Test Plan:
- NUM_OBJ=2, SPR 4x4. After reset, frame_tick with obj0=(10,20) colour 100 and obj1=(50,100) colour 001, both enabled -> 2 cycles plot=0, then 32 plots: obj0 (10..13, 20..23) row-major colour 100, then obj1 (50..53, 100..103) colour 001. frame_done pulses once.
- Second frame with obj0 moved to (10,18), bg 000 -> 16 erase plots at (10..13, 20..23) colour 000, 16 erase plots at obj1's old position, then 32 draws. Total 64 plots.
- plot_ready held 0 for 3 cycles while pixel 5 (11,21) is presented -> x/y/colour held for 4 cycles. Pixel 6 (12,21) follows. Exactly 32 plots accepted.
- obj0=(158,118), SPR 4x4, first frame -> only (158,118), (159,118), (158,119), (159,119) plotted. 12 cycles plot=0.
- frame_tick pulsed mid-frame with new positions -> overrun=1 for that cycle. The frame completes with the originally latched positions.
- resetn low mid-DRAW, then a frame -> outputs 0 during reset. The next frame has 0 erase plots and 32 draw plots.
- obj_en[1]=0 on a later frame -> obj1 erased (16 plots, bg colour) and not drawn. The following frame has no erase segment for obj1.

Source files
------------

// File: rtl/sprite_frame_renderer.sv
// Redraws NUM_OBJ sprites per frame: erase old footprints with bg_colour, then draw new ones.
// Latency: the first slot is registered on the frame_tick edge; one pixel or skipped slot per advancing cycle.
// Backpressure: a visible pixel holds x/y/colour/plot until plot_ready=1; clipped or inactive slots never stall.
module sprite_frame_renderer #(
    parameter int NUM_OBJ  = 2,
    parameter int SPR_W    = 8,
    parameter int SPR_H    = 8,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   frame_tick,
    input  logic [NUM_OBJ*X_W-1:0] obj_x,
    input  logic [NUM_OBJ*Y_W-1:0] obj_y,
    input  logic [NUM_OBJ*3-1:0]   obj_colour,
    input  logic [NUM_OBJ-1:0]     obj_en,
    input  logic [2:0]             bg_colour,
    input  logic                   plot_ready,
    output logic [X_W-1:0]         x,
    output logic [Y_W-1:0]         y,
    output logic [2:0]             colour,
    output logic                   plot,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   overrun
);
    localparam int LOG_W = $clog2(SPR_W);
    localparam int LOG_H = $clog2(SPR_H);
    localparam int CNT_W = LOG_W + LOG_H;
    localparam int IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = '1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OBJ - 1);

    typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [X_W-1:0]     sh_x   [NUM_OBJ];
    logic [Y_W-1:0]     sh_y   [NUM_OBJ];
    logic [2:0]         sh_col [NUM_OBJ];
    logic [NUM_OBJ-1:0] sh_en;
    logic [X_W-1:0]     old_x  [NUM_OBJ];
    logic [Y_W-1:0]     old_y  [NUM_OBJ];
    logic [NUM_OBJ-1:0] old_valid;

    logic               seg_act, adv, load;
    logic               nxt_act;
    logic [X_W-1:0]     base_x;
    logic [Y_W-1:0]     base_y;
    logic [2:0]         pix_col;
    logic [X_W:0]       sum_x;
    logic [Y_W:0]       sum_y;
    logic [X_W-1:0]     x_d;
    logic [Y_W-1:0]     y_d;
    logic [2:0]         colour_d;
    logic               plot_d, busy_d, frame_done_d, overrun_d;

    // The presented slot belongs to an active segment; slots advance unless a visible pixel is refused.
    assign seg_act = (state_q == ERASE) ? old_valid[idx_q] : sh_en[idx_q];
    assign adv     = !plot || plot_ready;

    // State and scan pointer register: the pointer always names the slot currently on the outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and pointer: inactive segments take one slot, active ones a full sprite scan.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    state_d = ERASE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            ERASE, DRAW: begin
                if (adv) begin
                    if (!seg_act || cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d   = '0;
                            state_d = (state_q == ERASE) ? DRAW : DONE;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output values for the slot being entered; clipping uses sums one bit wider than the coordinate.
    always_comb begin
        nxt_act = 1'b0;
        base_x  = sh_x[idx_d];
        base_y  = sh_y[idx_d];
        pix_col = sh_col[idx_d];
        if (state_d == ERASE) begin
            nxt_act = old_valid[idx_d];
            base_x  = old_x[idx_d];
            base_y  = old_y[idx_d];
            pix_col = bg_colour;
        end else if (state_d == DRAW) begin
            nxt_act = sh_en[idx_d];
        end
        sum_x = {1'b0, base_x} + (X_W+1)'(cnt_d[LOG_W-1:0]);
        sum_y = {1'b0, base_y} + (Y_W+1)'(cnt_d[CNT_W-1:LOG_W]);

        load         = (state_q == IDLE && frame_tick) ||
                       ((state_q == ERASE || state_q == DRAW) && adv);
        x_d          = x;
        y_d          = y;
        colour_d     = colour;
        plot_d       = plot;
        busy_d       = busy;
        frame_done_d = 1'b0;
        overrun_d    = frame_tick && (state_q != IDLE);
        if (load) begin
            x_d      = sum_x[X_W-1:0];
            y_d      = sum_y[Y_W-1:0];
            colour_d = pix_col;
            plot_d   = nxt_act && (sum_x < (X_W+1)'(SCREEN_W)) && (sum_y < (Y_W+1)'(SCREEN_H));
            busy_d   = 1'b1;
            if (state_d == DONE) begin
                plot_d       = 1'b0;
                busy_d       = 1'b0;
                frame_done_d = 1'b1;
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x          <= '0;
            y          <= '0;
            colour     <= '0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            x          <= x_d;
            y          <= y_d;
            colour     <= colour_d;
            plot       <= plot_d;
            busy       <= busy_d;
            frame_done <= frame_done_d;
            overrun    <= overrun_d;
        end
    end

    // Shadow copy taken at frame start; previous footprint committed in DONE for next frame's erase.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                sh_x[i]   <= '0;
                sh_y[i]   <= '0;
                sh_col[i] <= '0;
                old_x[i]  <= '0;
                old_y[i]  <= '0;
            end
            sh_en     <= '0;
            old_valid <= '0;
        end else begin
            if (state_q == IDLE && frame_tick) begin
                for (int i = 0; i < NUM_OBJ; i++) begin
                    sh_x[i]   <= obj_x[i*X_W +: X_W];
                    sh_y[i]   <= obj_y[i*Y_W +: Y_W];
                    sh_col[i] <= obj_colour[i*3 +: 3];
                end
                sh_en <= obj_en;
            end
            if (state_q == DONE) begin
                for (int i = 0; i < NUM_OBJ; i++) begin
                    old_x[i] <= sh_x[i];
                    old_y[i] <= sh_y[i];
                end
                old_valid <= sh_en;
            end
        end
    end
endmodule

// File: tb/tb_sprite_frame_renderer.sv
// Scoreboarded bench for sprite_frame_renderer (2 objects, 4x4 sprites).
// Stimulus pushes each frame's expected visible pixels; a monitor pops them on accepted plots.
// Backpressure is directed (stall on one pixel) or random depending on ready_mode.
module tb_sprite_frame_renderer;
    logic        clock = 0;
    logic        resetn = 0;
    logic        frame_tick = 0;
    logic [15:0] obj_x = '0;
    logic [13:0] obj_y = '0;
    logic [5:0]  obj_colour = '0;
    logic [1:0]  obj_en = '0;
    logic [2:0]  bg_colour = '0;
    logic        plot_ready = 1;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot, busy, frame_done, overrun;

    sprite_frame_renderer #(.NUM_OBJ(2), .SPR_W(4), .SPR_H(4), .X_W(8), .Y_W(7),
                            .SCREEN_W(160), .SCREEN_H(120)) dut (
        .clock(clock), .resetn(resetn), .frame_tick(frame_tick), .obj_x(obj_x), .obj_y(obj_y),
        .obj_colour(obj_colour), .obj_en(obj_en), .bg_colour(bg_colour), .plot_ready(plot_ready),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .frame_done(frame_done),
        .overrun(overrun)
    );

    always #5 clock = ~clock;

    int          vectors = 0;
    int          miscompares = 0;
    logic [17:0] exp_q[$];
    int          busy_cnt = 0, stall_cnt = 0, frame_acc = 0;
    int          done_cnt = 0, ovr_cnt = 0, exp_done = 0, exp_ovr = 0;
    int          ready_mode = 0;
    int          cost;
    bit          m_old_valid[2];
    int          m_old_x[2], m_old_y[2];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: expected visible pixels in scan order and expected non-stall busy cycles.
    task automatic issue_frame(input int x0, input int y0, input int c0, input int x1, input int y1,
                               input int c1, input logic [1:0] en, input int bg, output int exp_cost);
        int nx[2], ny[2], nc[2];
        nx[0] = x0; ny[0] = y0; nc[0] = c0;
        nx[1] = x1; ny[1] = y1; nc[1] = c1;
        exp_cost = 0;
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 2; i++) begin
                bit act = (ph == 0) ? m_old_valid[i] : en[i];
                int bx  = (ph == 0) ? m_old_x[i] : nx[i];
                int by  = (ph == 0) ? m_old_y[i] : ny[i];
                int col = (ph == 0) ? bg : nc[i];
                if (!act) begin
                    exp_cost += 1;
                end else begin
                    exp_cost += 16;
                    for (int r = 0; r < 4; r++)
                        for (int c = 0; c < 4; c++)
                            if (bx + c < 160 && by + r < 120)
                                exp_q.push_back({8'(bx + c), 7'(by + r), 3'(col)});
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            m_old_valid[i] = en[i];
            m_old_x[i] = nx[i];
            m_old_y[i] = ny[i];
        end
        @(posedge clock); #1;
        obj_x = {8'(x1), 8'(x0)};
        obj_y = {7'(y1), 7'(y0)};
        obj_colour = {3'(c1), 3'(c0)};
        obj_en = en;
        bg_colour = 3'(bg);
        frame_tick = 1;
        @(posedge clock); #1;
        frame_tick = 0;
        busy_cnt = 0; stall_cnt = 0; frame_acc = 0;
    endtask

    task automatic wait_done(input int exp_cost);
        int n = 0;
        bit got = 0;
        while (n < 3000 && !got) begin
            @(posedge clock); #2;
            n++;
            if (frame_done) got = 1;
        end
        check("frame_done_seen", 32'(got), 32'd1);
        if (got) begin
            exp_done++;
            check("frame_cycles", busy_cnt - stall_cnt, exp_cost);
            check("queue_drained", exp_q.size(), 0);
        end
        @(posedge clock); #1;
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clock); #1;
        resetn = 0;
        exp_q.delete();
        for (int i = 0; i < 2; i++) m_old_valid[i] = 0;
        repeat (cycles) @(negedge clock);
        check("reset_outputs", {x, y, colour, plot, busy, frame_done, overrun}, 32'd0);
        @(posedge clock); #1;
        resetn = 1;
    endtask

    // plot_ready driver: 0 always ready, 1 random, 2 refuse pixel index 5 for three cycles.
    initial begin
        int held = 0;
        forever begin
            @(posedge clock); #2;
            if (ready_mode == 1) plot_ready = ($urandom_range(0, 3) != 0);
            else if (ready_mode == 2 && plot && frame_acc == 5 && held < 3) begin
                plot_ready = 0;
                held++;
            end else begin
                plot_ready = 1;
                if (ready_mode != 2) held = 0;
            end
        end
    end

    // Monitor: pops expected pixel on each accepted plot and checks that refused pixels hold.
    initial begin
        bit          prev_stall = 0;
        logic [17:0] prev_pix = '0;
        logic [17:0] e;
        forever begin
            @(negedge clock);
            if (resetn) begin
                if (prev_stall) begin
                    check("hold_plot", 32'(plot), 32'd1);
                    check("hold_pixel", {x, y, colour}, prev_pix);
                end
                if (busy) busy_cnt++;
                if (plot && !plot_ready) stall_cnt++;
                if (frame_done) done_cnt++;
                if (overrun) ovr_cnt++;
                if (plot && plot_ready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL spurious_plot: got %0h expected no plot at %0t", {x, y, colour}, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("pixel", {x, y, colour}, e);
                        frame_acc++;
                    end
                end
                prev_stall = plot && !plot_ready;
                prev_pix = {x, y, colour};
            end else begin
                prev_stall = 0;
            end
        end
    end

    initial begin
        for (int i = 0; i < 2; i++) begin m_old_valid[i] = 0; m_old_x[i] = 0; m_old_y[i] = 0; end
        repeat (3) @(negedge clock);
        check("reset_outputs", {x, y, colour, plot, busy, frame_done, overrun}, 32'd0);
        @(posedge clock); #1;
        resetn = 1;

        // Clipping: obj0 near the bottom-right corner, first frame after reset.
        issue_frame(158, 118, 5, 50, 100, 1, 2'b01, 0, cost);
        wait_done(cost);
        do_reset(2);

        // Basic draw with a three-cycle stall on pixel 5, then a move with full erase.
        ready_mode = 2;
        issue_frame(10, 20, 4, 50, 100, 1, 2'b11, 0, cost);
        wait_done(cost);
        check("stall_cycles", stall_cnt, 3);
        ready_mode = 0;
        issue_frame(10, 18, 4, 50, 100, 1, 2'b11, 0, cost);
        wait_done(cost);

        // frame_tick while busy: overrun pulse, latched frame unaffected.
        issue_frame(30, 40, 2, 70, 60, 6, 2'b11, 3, cost);
        repeat (20) @(posedge clock);
        #1;
        obj_x = {8'd1, 8'd2}; obj_y = {7'd3, 7'd4}; frame_tick = 1;
        @(posedge clock); #1;
        frame_tick = 0;
        exp_ovr++;
        wait_done(cost);
        check("overrun_count", ovr_cnt, exp_ovr);

        // Reset mid-DRAW, then a frame with no erase.
        issue_frame(80, 50, 7, 90, 60, 3, 2'b11, 0, cost);
        repeat (40) @(posedge clock);
        do_reset(2);
        issue_frame(12, 14, 5, 100, 70, 2, 2'b11, 1, cost);
        wait_done(cost);

        // Disable obj1: erased, not drawn, then absent from the following erase.
        issue_frame(12, 14, 5, 100, 70, 2, 2'b01, 1, cost);
        wait_done(cost);
        issue_frame(20, 24, 6, 100, 70, 2, 2'b01, 2, cost);
        wait_done(cost);

        // Randomized frames with random backpressure, biased toward screen edges.
        ready_mode = 1;
        for (int f = 0; f < 14; f++) begin
            int px[2], py[2];
            for (int i = 0; i < 2; i++) begin
                px[i] = ($urandom_range(0, 1) == 1) ? $urandom_range(150, 170) : $urandom_range(0, 255);
                py[i] = ($urandom_range(0, 1) == 1) ? $urandom_range(110, 127) : $urandom_range(0, 127);
            end
            issue_frame(px[0], py[0], $urandom_range(0, 7), px[1], py[1], $urandom_range(0, 7),
                        2'($urandom_range(0, 3)), $urandom_range(0, 7), cost);
            wait_done(cost);
        end
        ready_mode = 0;

        repeat (3) @(posedge clock);
        #2;
        check("frame_done_count", done_cnt, exp_done);
        check("overrun_total", ovr_cnt, exp_ovr);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
